hex_scroll_ctrl: RTL and testbench



---
 rtl/hex_scroll_pkg.sv | 26 ++
 rtl/scroll_prescaler.sv | 49 ++++
 rtl/hex_scroll_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// ----------------------------------------------------------------------------
// hex_scroll_pkg
// Shared types and constants for the seven-segment scroller.
//   state_e     : sequencer states (IDLE, RUN, PAUSED)
//   BLANK       : active-low glyph with every segment off
//   NUM_DIGITS  : number of HEX digits in the display window
//   GLYPH_*     : active-low {g,f,e,d,c,b,a} glyphs for the "ScroLL" banner
// ----------------------------------------------------------------------------
package hex_scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    localparam logic [6:0] BLANK      = 7'h7F;
    localparam int         NUM_DIGITS = 6;

    localparam logic [6:0] GLYPH_S = 7'b0010010;
    localparam logic [6:0] GLYPH_C = 7'b0100111;
    localparam logic [6:0] GLYPH_R = 7'b0101111;
    localparam logic [6:0] GLYPH_O = 7'b0100011;
    localparam logic [6:0] GLYPH_L = 7'b1000111;

endpackage

// File: rtl/scroll_prescaler.sv
// ----------------------------------------------------------------------------
// scroll_prescaler
// Divides the system clock down to the scroll step rate.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   en_i        : count this cycle
//   clr_i       : force the count to zero (overrides en_i)
//   speed_sel_i : step period = TICK_CYCLES >> speed_sel_i (at least 1)
//   tick_o      : one-cycle pulse on the last count of a period
// With neither en_i nor clr_i asserted the count is held.
// ----------------------------------------------------------------------------
module scroll_prescaler #(
    parameter int TICK_CYCLES = 12_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] speed_sel_i,
    output logic       tick_o
);

    localparam int CW = $clog2(TICK_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] limit;
    logic [CW-1:0] last;

    // A shifted period of zero degenerates to a tick every enabled cycle.
    always_comb begin
        limit = CW'(TICK_CYCLES >> speed_sel_i);
        last  = (limit == '0) ? '0 : limit - 1'b1;
    end

    // ">=" rather than "==": a speed change that lands the count beyond the
    // new period still produces a tick instead of running to wrap-around.
    assign tick_o = en_i && !clr_i && (cnt_q >= last);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// hex_scroll_ctrl
// Scrolls a stored glyph message across six active-low seven-segment digits
// (HEX5 leftmost ... HEX0 rightmost). The message loops with six trailing
// blanks so the text leaves the display fully before re-entering.
//   CLOCK_50         : system clock
//   RESET            : synchronous active-high reset
//   wr_en/addr/data  : glyph buffer write port (accepted in any state)
//   msg_len          : message length, captured on start, clamped to MSG_MAX
//   start / stop     : one-cycle control pulses (stop wins when both)
//   pause            : level, freezes scrolling while high
//   dir              : 0 = text moves left (pos++), 1 = right (pos--)
//   speed_sel        : step period = TICK_CYCLES >> speed_sel
//   busy             : high in RUN or PAUSED
//   pos              : current window start index
//   HEX0..HEX5       : registered digit outputs
// ----------------------------------------------------------------------------
module hex_scroll_ctrl #(
    parameter int         MSG_MAX     = 32,
    parameter int         TICK_CYCLES = 12_500_000,
    parameter logic [6:0] BLANK       = hex_scroll_pkg::BLANK
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_MAX)-1:0] wr_addr,
    input  logic [6:0]                 wr_data,
    input  logic [$clog2(MSG_MAX):0]   msg_len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    input  logic                       dir,
    input  logic [1:0]                 speed_sel,
    output logic                       busy,
    output logic [$clog2(MSG_MAX):0]   pos,
    output logic [6:0]                 HEX0,
    output logic [6:0]                 HEX1,
    output logic [6:0]                 HEX2,
    output logic [6:0]                 HEX3,
    output logic [6:0]                 HEX4,
    output logic [6:0]                 HEX5
);

    import hex_scroll_pkg::*;

    localparam int AW = $clog2(MSG_MAX);
    localparam int PW = AW + 1;
    // Wide enough for pos + 5 with pos up to MSG_MAX + 5.
    localparam int LW = AW + 2;

    state_e        state_q;
    logic [PW-1:0] pos_q;
    logic [PW-1:0] len_q;
    logic [6:0]    buf_q [MSG_MAX];
    logic [6:0]    hex_q [NUM_DIGITS];

    logic [LW-1:0] loop_len;
    logic [PW-1:0] len_clamped;
    logic [PW-1:0] pos_step;
    logic          start_ok;
    logic          tick;
    logic          presc_en;
    logic          presc_clr;
    logic [LW-1:0] win_idx [NUM_DIGITS];
    logic [6:0]    hex_d   [NUM_DIGITS];

    assign loop_len    = LW'(len_q) + LW'(NUM_DIGITS);
    assign start_ok    = start && (msg_len != '0);
    assign len_clamped = (msg_len > PW'(MSG_MAX)) ? PW'(MSG_MAX) : msg_len;

    // Counting follows the effective run condition of the current cycle, so
    // a freeze takes hold on the cycle pause rises and the held count resumes
    // on the cycle it falls. Stop and a restart both zero the count.
    assign presc_en  = (state_q != IDLE) && !pause;
    assign presc_clr = (state_q == IDLE) || stop || start_ok;

    scroll_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk_i       (CLOCK_50),
        .rst_i       (RESET),
        .en_i        (presc_en),
        .clr_i       (presc_clr),
        .speed_sel_i (speed_sel),
        .tick_o      (tick)
    );

    always_comb begin
        if (dir) begin
            pos_step = (pos_q == '0) ? PW'(loop_len - 1'b1) : pos_q - 1'b1;
        end else begin
            pos_step = (LW'(pos_q) == loop_len - 1'b1) ? '0 : pos_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
        end else if (stop) begin
            state_q <= IDLE;
            pos_q   <= '0;
        end else if (start_ok) begin
            state_q <= RUN;
            pos_q   <= '0;
            len_q   <= len_clamped;
        end else if (state_q != IDLE) begin
            state_q <= pause ? PAUSED : RUN;
            if (tick) begin
                pos_q <= pos_step;
            end
        end
    end

    // NOTE: the glyph buffer has no reset; it is plain RAM whose contents are
    // only meaningful once written, and a reset term would block RAM mapping.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    // Window mux. pos + k never reaches twice the loop length, so one
    // conditional subtract is a full modulo. A write landing on a displayed
    // address this cycle is forwarded so the pins show it one cycle later.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            // NOTE: every combinational output gets a default before any
            // conditional assignment so no path can infer a latch.
            hex_d[k]   = BLANK;
            win_idx[k] = LW'(pos_q) + LW'(k);
            if (win_idx[k] >= loop_len) begin
                win_idx[k] = win_idx[k] - loop_len;
            end
            if (win_idx[k] < LW'(len_q)) begin
                if (wr_en && (wr_addr == win_idx[k][AW-1:0])) begin
                    hex_d[k] = wr_data;
                end else begin
                    hex_d[k] = buf_q[win_idx[k][AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (RESET || (state_q == IDLE)) begin
                hex_q[k] <= BLANK;
            end else begin
                hex_q[k] <= hex_d[k];
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign pos  = pos_q;
    assign HEX5 = hex_q[0];
    assign HEX4 = hex_q[1];
    assign HEX3 = hex_q[2];
    assign HEX2 = hex_q[3];
    assign HEX1 = hex_q[4];
    assign HEX0 = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hex_scroll_ctrl
// Self-checking bench for hex_scroll_ctrl with a short prescaler period.
// ----------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

    import hex_scroll_pkg::*;

    localparam int MSG_MAX = 32;
    localparam int TICK    = 4;

    logic       CLOCK_50  = 1'b0;
    logic       RESET     = 1'b1;
    logic       wr_en     = 1'b0;
    logic [4:0] wr_addr   = '0;
    logic [6:0] wr_data   = '0;
    logic [5:0] msg_len   = '0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic       pause     = 1'b0;
    logic       dir       = 1'b0;
    logic [1:0] speed_sel = '0;
    logic       busy;
    logic [5:0] pos;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_scroll_ctrl #(
        .MSG_MAX     (MSG_MAX),
        .TICK_CYCLES (TICK),
        .BLANK       (7'h7F)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .msg_len   (msg_len),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .dir       (dir),
        .speed_sel (speed_sel),
        .busy      (busy),
        .pos       (pos),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    // ---------------- reference model ----------------
    // The display is a window of six slots over a cyclic sequence made of the
    // message followed by six blanks; position advances on every period-th
    // active cycle.
    logic [6:0] m_mem [MSG_MAX];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    int         m_len = 0;
    int         m_cnt = 0;
    logic [6:0] m_hex [6] = '{default: 7'h7F};

    function automatic logic [6:0] m_glyph(int k);
        int cyc_len;
        int idx;
        cyc_len = m_len + 6;
        idx     = (m_pos + k) % cyc_len;
        return (idx < m_len) ? m_mem[idx] : 7'h7F;
    endfunction

    task automatic model_edge();
        int period;
        int cyc_len;
        if (wr_en) m_mem[wr_addr] = wr_data;
        if (RESET) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_len    = 0;
            m_cnt    = 0;
            for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
        end else begin
            for (int k = 0; k < 6; k++) m_hex[k] = m_active ? m_glyph(k) : 7'h7F;
            if (stop) begin
                m_active = 1'b0;
                m_pos    = 0;
                m_cnt    = 0;
            end else if (start && msg_len != 0) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_cnt    = 0;
                m_len    = (int'(msg_len) > MSG_MAX) ? MSG_MAX : int'(msg_len);
            end else if (m_active && !pause) begin
                period = TICK >> speed_sel;
                if (period < 1) period = 1;
                if (m_cnt + 1 >= period) begin
                    m_cnt   = 0;
                    cyc_len = m_len + 6;
                    m_pos   = dir ? (m_pos + cyc_len - 1) % cyc_len : (m_pos + 1) % cyc_len;
                end else begin
                    m_cnt++;
                end
            end else if (!m_active) begin
                m_cnt = 0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic cycle();
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("busy", 32'(busy), 32'(m_active));
        check("pos", 32'(pos), 32'(m_pos));
        check("HEX5", 32'(HEX5), 32'(m_hex[0]));
        check("HEX4", 32'(HEX4), 32'(m_hex[1]));
        check("HEX3", 32'(HEX3), 32'(m_hex[2]));
        check("HEX2", 32'(HEX2), 32'(m_hex[3]));
        check("HEX1", 32'(HEX1), 32'(m_hex[4]));
        check("HEX0", 32'(HEX0), 32'(m_hex[5]));
    endtask

    task automatic check_all_blank(string name);
        check({name, " HEX5"}, 32'(HEX5), 32'h7F);
        check({name, " HEX4"}, 32'(HEX4), 32'h7F);
        check({name, " HEX3"}, 32'(HEX3), 32'h7F);
        check({name, " HEX2"}, 32'(HEX2), 32'h7F);
        check({name, " HEX1"}, 32'(HEX1), 32'h7F);
        check({name, " HEX0"}, 32'(HEX0), 32'h7F);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         start;
        bit         pause;
        bit         dir;
        bit         busy;
        int         pos;
        logic [6:0] h5;
        logic [6:0] h4;
        logic [6:0] h0;
    } vec_t;

    vec_t tbl [36];

    // Window views of "ScroLL" + 6 blanks as {HEX5, HEX4, HEX0}.
    function automatic vec_t mk(bit st, bit pa, bit dr, int p, int view);
        vec_t v;
        v.start = st;
        v.pause = pa;
        v.dir   = dr;
        v.busy  = 1'b1;
        v.pos   = p;
        case (view)
            0:       begin v.h5 = GLYPH_S; v.h4 = GLYPH_C; v.h0 = GLYPH_L; end
            1:       begin v.h5 = GLYPH_C; v.h4 = GLYPH_R; v.h0 = BLANK;   end
            2:       begin v.h5 = GLYPH_R; v.h4 = GLYPH_O; v.h0 = BLANK;   end
            11:      begin v.h5 = BLANK;   v.h4 = GLYPH_S; v.h0 = GLYPH_L; end
            default: begin v.h5 = BLANK;   v.h4 = BLANK;   v.h0 = BLANK;   end
        endcase
        return v;
    endfunction

    logic [6:0] msg [6];

    initial begin
        msg = '{GLYPH_S, GLYPH_C, GLYPH_R, GLYPH_O, GLYPH_L, GLYPH_L};

        // Start edge: pins still blank (state was IDLE), then 4-cycle steps.
        tbl[0] = mk(1, 0, 0, 0, -1);
        for (int i = 1; i <= 3; i++) tbl[i] = mk(0, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 1, 0);
        tbl[5] = mk(0, 0, 0, 1, 1);
        tbl[6] = mk(0, 0, 0, 1, 1);
        // Pause for 10 cycles at count 2: position frozen, count held.
        for (int i = 7; i <= 16; i++) tbl[i] = mk(0, 1, 0, 1, 1);
        tbl[17] = mk(0, 0, 0, 1, 1);
        tbl[18] = mk(0, 0, 0, 2, 1);
        tbl[19] = mk(0, 0, 0, 2, 2);
        tbl[20] = mk(0, 0, 0, 2, 2);
        // Reverse direction: 2 -> 1 -> 0 -> 11.
        tbl[21] = mk(0, 0, 1, 2, 2);
        tbl[22] = mk(0, 0, 1, 1, 2);
        for (int i = 23; i <= 25; i++) tbl[i] = mk(0, 0, 1, 1, 1);
        tbl[26] = mk(0, 0, 1, 0, 1);
        for (int i = 27; i <= 29; i++) tbl[i] = mk(0, 0, 1, 0, 0);
        tbl[30] = mk(0, 0, 1, 11, 0);
        tbl[31] = mk(0, 0, 1, 11, 11);
        // Forward again: 11 wraps to 0.
        tbl[32] = mk(0, 0, 0, 11, 11);
        tbl[33] = mk(0, 0, 0, 11, 11);
        tbl[34] = mk(0, 0, 0, 0, 11);
        tbl[35] = mk(0, 0, 0, 0, 0);

        // Reset state.
        RESET = 1'b1;
        cycle();
        cycle();
        check("reset busy", 32'(busy), 32'd0);
        check("reset pos", 32'(pos), 32'd0);
        check_all_blank("reset");
        RESET = 1'b0;

        // Load the whole buffer: banner at 0..5, noise beyond.
        for (int a = 0; a < MSG_MAX; a++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(a);
            wr_data = (a < 6) ? msg[a] : 7'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        cycle();
        check("idle HEX0 blank", 32'(HEX0), 32'h7F);
        check("idle busy", 32'(busy), 32'd0);

        msg_len   = 6'd6;
        speed_sel = 2'd0;
        for (int i = 0; i < 36; i++) begin
            start = tbl[i].start;
            pause = tbl[i].pause;
            dir   = tbl[i].dir;
            cycle();
            check($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d pos", i), 32'(pos), 32'(tbl[i].pos));
            check($sformatf("tbl%0d HEX5", i), 32'(HEX5), 32'(tbl[i].h5));
            check($sformatf("tbl%0d HEX4", i), 32'(HEX4), 32'(tbl[i].h4));
            check($sformatf("tbl%0d HEX0", i), 32'(HEX0), 32'(tbl[i].h0));
        end
        start = 1'b0;
        pause = 1'b0;
        dir   = 1'b0;

        // Reset while running: blank at once, position parked.
        RESET = 1'b1;
        cycle();
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset pos", 32'(pos), 32'd0);
        check_all_blank("midrun reset");
        RESET = 1'b0;
        repeat (10) cycle();
        check("post reset pos", 32'(pos), 32'd0);
        check("post reset busy", 32'(busy), 32'd0);

        // Oversized length clamps to 32, loop of 38; step every cycle.
        msg_len   = 6'd40;
        speed_sel = 2'd3;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        check("clamp busy", 32'(busy), 32'd1);
        repeat (37) cycle();
        check("clamp pos last", 32'(pos), 32'd37);
        cycle();
        check("clamp pos wrap", 32'(pos), 32'd0);

        // start and stop together while running: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        check("start+stop run busy", 32'(busy), 32'd0);
        start = 1'b0;
        stop  = 1'b0;
        cycle();
        check_all_blank("after stop");
        // Same from IDLE.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        check("start+stop idle busy", 32'(busy), 32'd0);
        cycle();
        check_all_blank("start+stop idle");

        // Zero length start is ignored.
        msg_len = 6'd0;
        start   = 1'b1;
        cycle();
        start = 1'b0;
        check("len0 busy", 32'(busy), 32'd0);
        cycle();
        check("len0 busy later", 32'(busy), 32'd0);

        // Write at pos 0 while running appears on HEX5 one cycle later.
        msg_len   = 6'd6;
        speed_sel = 2'd0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        check("pre write HEX5", 32'(HEX5), 32'(GLYPH_S));
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = GLYPH_O;
        cycle();
        wr_en = 1'b0;
        check("write HEX5", 32'(HEX5), 32'(GLYPH_O));
        check("write pos", 32'(pos), 32'd0);
        // Write outside the message leaves the display alone.
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 7'h00;
        cycle();
        wr_en = 1'b0;
        check("far write HEX5", 32'(HEX5), 32'(GLYPH_O));
        check("far write HEX0", 32'(HEX0), 32'(GLYPH_L));

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            RESET   = ($urandom_range(0, 499) == 0);
            start   = ($urandom_range(0, 15) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            msg_len = 6'($urandom_range(0, 40));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 5'($urandom);
            wr_data = 7'($urandom);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) speed_sel = 2'($urandom);
            cycle();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
